idli_sqi_mem_m: RTL and testbench
=================================

IDLI_SQI_MEM_M -- requirements
Module: idli_sqi_mem_m

Interface
REQ-001 Parameter: DUMMY_NIBBLES, default 2, number of SCK edges skipped between the address and READ data.
REQ-002 Clock domain: one clock; reset is asynchronous and active-low.
REQ-003 i_mem_gck  input  1  clock; this is the SQI SCK, and all inputs are sampled on its rising edge.
REQ-004 i_mem_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_mem_cs  input  1  chip select; high = deselect/abort, low = transaction active.
REQ-006 i_mem_sio  input  4  nibble driven by the initiator.
REQ-007 o_mem_sio  output  4  read-data nibble driven to the initiator.
REQ-008 o_mem_mode  output  sqi_mode_t  SQI_MODE_OUT while this block drives o_mem_sio, else SQI_MODE_IN.
REQ-009 o_mem_addr  output  16  byte address to the backing storage.
REQ-010 i_mem_rd_data  input  8  storage read byte at o_mem_addr, combinational, same cycle.
REQ-011 o_mem_wr_data  output  8  byte to be written.
REQ-012 o_mem_wr_en  output  1  storage write strobe; the write commits on the next rising edge.

Function
REQ-013 The block SHALL be the SQI memory responder: it accepts the instruction, address and data stream from the SQI controller and services reads and writes against byte storage.
REQ-014 FSM states SHALL be INSTR, ADDR, DUMMY, DATA and IGNORE, with a 2-bit nibble counter nib_q.
REQ-015 An edge with i_mem_cs=1 SHALL force state INSTR and nib_q=0 in any state, aborting any transaction; no write is issued on that edge.
REQ-016 INSTR SHALL shift two nibbles, MSB nibble first. On the second nibble the byte is decoded:
- 0x03 (READ) -> ADDR
- 0x02 (WRITE) -> ADDR
- any other value -> IGNORE
REQ-017 ADDR SHALL shift four nibbles, big-endian, into addr_q. After the fourth nibble:
- READ -> DUMMY
- WRITE -> DATA
REQ-018 DUMMY SHALL discard DUMMY_NIBBLES edges, then go to DATA.
REQ-019 IGNORE SHALL hold until CS goes high, with outputs idle.
REQ-020 READ DATA behaviour:
- o_mem_mode=SQI_MODE_OUT.
- o_mem_sio = i_mem_rd_data[7:4] when nib_q[0]=0, and [3:0] when nib_q[0]=1.
- The high-nibble value is valid before the first DATA edge, so there is zero-edge latency from the end of DUMMY.
REQ-021 WRITE DATA behaviour:
- The first nibble is latched as the high nibble.
- On the second nibble: o_mem_wr_data = {high, i_mem_sio} and o_mem_wr_en=1 combinationally for that edge.
REQ-022 After each completed byte, addr_q SHALL increment by 1 modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-023 DATA SHALL continue indefinitely until CS goes high.
REQ-024 o_mem_addr SHALL equal addr_q at all times.
REQ-025 o_mem_wr_en SHALL be 0 outside WRITE DATA.
REQ-026 o_mem_mode SHALL be SQI_MODE_IN outside READ DATA.
REQ-027 Observed over a 16b word, nibble order SHALL be big-endian, i.e. the reverse of the core's little-endian order.

Reset
REQ-028 Asynchronous reset SHALL set:
- state=INSTR, nib_q=0
- addr_q=0x0000
- the instruction register and the write high-nibble register to 0
REQ-029 During reset the outputs SHALL be:
- o_mem_wr_en=0
- o_mem_mode=SQI_MODE_IN
- o_mem_sio=0
- o_mem_addr=0
REQ-030 Reset asserted mid-transaction SHALL discard the partial byte and not write it.

Structure
REQ-031 SQI_INSTR_READ (8'h03) and SQI_INSTR_WRITE (8'h02) SHALL live in idli_pkg, alongside the existing sqi_mode_t.
REQ-032 The FSM state typedef SHALL be local to the module.
REQ-033 There SHALL be no sub-module; the storage is external, and the bench provides a 64 KiB byte array model.

Verification
REQ-034 WRITE test: CS high then low; nibbles 0,2, 1,2,3,4, A,B, C,D. Required response:
- wr_en pulses twice.
- Storage[0x1234]=0xAB and [0x1235]=0xCD.
- o_mem_mode stays IN throughout.
REQ-035 READ test: preload [0x1234]=0xAB, [0x1235]=0xCD; send 0,3, 1,2,3,4, then 2 dummy edges. Required response: o_mem_sio = A,B,C,D on the next four edges, with o_mem_mode=OUT.
REQ-036 Wrap test: WRITE at 0xFFFF of bytes 0x11, 0x22. Required response: [0xFFFF]=0x11 and [0x0000]=0x22.
REQ-037 Bad instruction test: send 0x05, then 8 further nibbles. Required response: no wr_en, mode IN; a following CS-high then valid READ works normally.
REQ-038 Abort test:
- CS high after the first data nibble of a WRITE -> no write.
- Async reset asserted mid-ADDR -> all outputs take their reset values.
- The next transaction completes correctly.
REQ-039 Back-to-back test: READ of 4 bytes, CS high for 2 edges, then a WRITE. Required response: both transactions are correct, with mode returning to IN on the CS-high edge.

Source files
------------

// File: rtl/idli_pkg.sv
// Shared SQI definitions: pin direction mode and instruction opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package idli_pkg;

    // Direction of the shared SIO pins as seen from the memory responder.
    typedef enum logic {
        SQI_MODE_IN  = 1'b0,
        SQI_MODE_OUT = 1'b1
    } sqi_mode_t;

    localparam logic [7:0] SQI_INSTR_READ  = 8'h03;
    localparam logic [7:0] SQI_INSTR_WRITE = 8'h02;

endpackage

// File: rtl/idli_sqi_mem_m_if.sv
// SQI memory responder bus: initiator pins plus the byte-storage port.
// Latency: n/a (wiring only).
// Backpressure: none; the SQI link and storage port are free-running.
//   cs       chip select, high = deselect/abort
//   sio_in   nibble driven by the initiator
//   sio_out  read-data nibble driven back to the initiator
//   mode     SQI_MODE_OUT while the responder drives sio_out
//   addr     byte address to storage
//   rd_data  storage byte at addr (combinational)
//   wr_data  byte to write, wr_en commits it on the next rising edge
interface idli_sqi_mem_m_if;
    import idli_pkg::*;

    logic       cs;
    logic [3:0] sio_in;
    logic [3:0] sio_out;
    sqi_mode_t  mode;
    logic [15:0] addr;
    logic [7:0] rd_data;
    logic [7:0] wr_data;
    logic       wr_en;

    // Initiator plus storage side.
    modport master (
        output cs, sio_in, rd_data,
        input  sio_out, mode, addr, wr_data, wr_en
    );

    // Memory responder side.
    modport slave (
        input  cs, sio_in, rd_data,
        output sio_out, mode, addr, wr_data, wr_en
    );

endinterface

// File: rtl/idli_sqi_mem_m.sv
// SQI memory responder: decodes READ/WRITE instruction, 16b address, serves byte storage.
// Latency: read nibble valid before the first DATA edge; write strobe on the second nibble's edge.
// Backpressure: none; CS high aborts at any edge and returns to instruction fetch.
//   i_mem_gck    SQI SCK, inputs sampled on its rising edge
//   i_mem_rst_n  asynchronous active-low reset
//   mem          idli_sqi_mem_m_if.slave (SIO pins, mode, storage port)
module idli_sqi_mem_m
    import idli_pkg::*;
#(
    parameter int DUMMY_NIBBLES = 2   // 0..4 edges between address and read data
) (
    input  logic            i_mem_gck,
    input  logic            i_mem_rst_n,
    idli_sqi_mem_m_if.slave mem
);

    typedef enum logic [2:0] {
        ST_INSTR,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_t;

    // nib_q is shared by every phase, so the dummy phase count must fit in it.
    localparam logic [1:0] DUMMY_LAST = 2'(DUMMY_NIBBLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  nib_q, nib_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  instr_q, instr_d;
    logic [3:0]  hi_q, hi_d;
    logic [7:0]  instr_shift;

    assign instr_shift = {instr_q[3:0], mem.sio_in};

    // State register.
    always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
        if (!i_mem_rst_n) begin
            state_q <= ST_INSTR;
            nib_q   <= 2'd0;
            addr_q  <= 16'h0000;
            instr_q <= 8'h00;
            hi_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            hi_q    <= hi_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        hi_d    = hi_q;

        if (mem.cs) begin
            state_d = ST_INSTR;
            nib_d   = 2'd0;
        end else begin
            unique case (state_q)
                ST_INSTR: begin
                    instr_d = instr_shift;
                    nib_d   = nib_q + 2'd1;
                    if (nib_q[0]) begin
                        nib_d   = 2'd0;
                        state_d = (instr_shift == SQI_INSTR_READ ||
                                   instr_shift == SQI_INSTR_WRITE) ? ST_ADDR : ST_IGNORE;
                    end
                end
                ST_ADDR: begin
                    addr_d = {addr_q[11:0], mem.sio_in};
                    nib_d  = nib_q + 2'd1;
                    if (nib_q == 2'd3) begin
                        nib_d = 2'd0;
                        if (instr_q == SQI_INSTR_READ && DUMMY_NIBBLES != 0)
                            state_d = ST_DUMMY;
                        else
                            state_d = ST_DATA;
                    end
                end
                ST_DUMMY: begin
                    nib_d = nib_q + 2'd1;
                    if (nib_q == DUMMY_LAST) begin
                        nib_d   = 2'd0;
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Bit 0 alone tracks high/low nibble of the current byte.
                    nib_d = {1'b0, ~nib_q[0]};
                    if (!nib_q[0])
                        hi_d = mem.sio_in;
                    else
                        addr_d = addr_q + 16'd1;
                end
                ST_IGNORE: begin
                end
                default: begin
                    state_d = ST_INSTR;
                    nib_d   = 2'd0;
                end
            endcase
        end
    end

    // Outputs: a pure function of state plus the same-edge inputs.
    always_comb begin
        mem.sio_out = 4'h0;
        mem.mode    = SQI_MODE_IN;
        mem.wr_en   = 1'b0;
        mem.wr_data = 8'h00;

        if (state_q == ST_DATA) begin
            if (instr_q == SQI_INSTR_READ) begin
                mem.mode    = SQI_MODE_OUT;
                mem.sio_out = nib_q[0] ? mem.rd_data[3:0] : mem.rd_data[7:4];
            end else if (instr_q == SQI_INSTR_WRITE && nib_q[0] && !mem.cs) begin
                // A CS-high edge aborts, so a half-received byte is never written.
                mem.wr_en   = 1'b1;
                mem.wr_data = {hi_q, mem.sio_in};
            end
        end
    end

    assign mem.addr = addr_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
module tb_idli_sqi_mem_m;
    import idli_pkg::*;

    localparam int DUMMY = 2;

    logic clk = 1'b0;
    logic rst_n;

    idli_sqi_mem_m_if bus();

    idli_sqi_mem_m #(.DUMMY_NIBBLES(DUMMY)) dut (
        .i_mem_gck   (clk),
        .i_mem_rst_n (rst_n),
        .mem         (bus)
    );

    always #5 clk = ~clk;

    // Backing storage: 64 KiB, preloaded with a known pattern once.
    logic [7:0] mem_store [0:65535];
    logic [7:0] ref_mem   [0:65535];
    logic       seeded = 1'b0;

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37) ^ (i >> 8) ^ 8'h5A);
    endfunction

    assign bus.rd_data = mem_store[bus.addr];

    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 65536; i++) mem_store[i] <= pat(i);
            seeded <= 1'b1;
        end else if (bus.wr_en) begin
            mem_store[bus.addr] <= bus.wr_data;
        end
    end

    // Strobe counters, sampled mid-cycle.
    int wr_cnt  = 0;
    int out_cnt = 0;
    always @(negedge clk) begin
        if (bus.wr_en) wr_cnt <= wr_cnt + 1;
        if (bus.mode == SQI_MODE_OUT) out_cnt <= out_cnt + 1;
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One SCK edge: drive inputs, capture what the responder presents for that edge.
    task automatic edge_io(input logic cs, input logic [3:0] nib,
                           output logic [3:0] so, output logic mo);
        bus.cs     = cs;
        bus.sio_in = nib;
        #2;
        so = bus.sio_out;
        mo = (bus.mode == SQI_MODE_OUT);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic cs, input logic [3:0] nib);
        logic [3:0] so;
        logic       mo;
        edge_io(cs, nib, so, mo);
    endtask

    task automatic cs_idle(input int n);
        for (int i = 0; i < n; i++) send(1'b1, 4'($urandom));
    endtask

    task automatic send_hdr(input logic [7:0] instr, input logic [15:0] a);
        send(1'b0, instr[7:4]);
        send(1'b0, instr[3:0]);
        for (int k = 3; k >= 0; k--) send(1'b0, a[k*4 +: 4]);
    endtask

    logic [7:0] txq[$];

    // Full WRITE transaction of txq at address a, followed by one CS-high edge.
    task automatic do_write(input logic [15:0] a);
        int w0, o0, n;
        logic [15:0] ai;
        w0 = wr_cnt;
        o0 = out_cnt;
        n  = txq.size();
        send_hdr(SQI_INSTR_WRITE, a);
        for (int i = 0; i < n; i++) begin
            send(1'b0, txq[i][7:4]);
            send(1'b0, txq[i][3:0]);
            ai = a + 16'(i);
            ref_mem[ai] = txq[i];
        end
        send(1'b1, 4'h0);
        chk("wr_strobes", 32'(wr_cnt - w0), 32'(n));
        chk("wr_mode_in", 32'(out_cnt - o0), 32'd0);
        for (int i = 0; i < n; i++) begin
            ai = a + 16'(i);
            chk("wr_mem", {24'h0, mem_store[ai]}, {24'h0, ref_mem[ai]});
        end
    endtask

    // READ transaction of n bytes; leaves CS low (caller ends it).
    task automatic do_read(input logic [15:0] a, input int n);
        logic [3:0]  so;
        logic        mo;
        logic [15:0] ai;
        send_hdr(SQI_INSTR_READ, a);
        for (int i = 0; i < DUMMY; i++) send(1'b0, 4'($urandom));
        for (int i = 0; i < n; i++) begin
            ai = a + 16'(i);
            edge_io(1'b0, 4'($urandom), so, mo);
            chk("rd_hi", {28'h0, so}, {28'h0, ref_mem[ai][7:4]});
            chk("rd_mode_hi", {31'h0, mo}, 32'd1);
            edge_io(1'b0, 4'($urandom), so, mo);
            chk("rd_lo", {28'h0, so}, {28'h0, ref_mem[ai][3:0]});
            chk("rd_mode_lo", {31'h0, mo}, 32'd1);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wr_en"}, {31'h0, bus.wr_en}, 32'd0);
        chk({tag, "_mode"}, {31'h0, bus.mode == SQI_MODE_OUT}, 32'd0);
        chk({tag, "_sio"}, {28'h0, bus.sio_out}, 32'd0);
        chk({tag, "_addr"}, {16'h0, bus.addr}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w0, o0, bad;
        logic [15:0] a;
        logic [7:0]  keep;

        for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
        rst_n      = 1'b0;
        bus.cs     = 1'b1;
        bus.sio_in = 4'h0;
        #1;
        chk_idle_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cs_idle(1);

        // Directed WRITE: 0,2 1,2,3,4 A,B C,D
        txq = '{8'hAB, 8'hCD};
        do_write(16'h1234);
        chk("wr_1234", {24'h0, mem_store[16'h1234]}, 32'hAB);
        chk("wr_1235", {24'h0, mem_store[16'h1235]}, 32'hCD);

        // Directed READ back of the same bytes.
        do_read(16'h1234, 2);
        cs_idle(1);

        // Address wrap.
        txq = '{8'h11, 8'h22};
        do_write(16'hFFFF);
        chk("wrap_ffff", {24'h0, mem_store[16'hFFFF]}, 32'h11);
        chk("wrap_0000", {24'h0, mem_store[16'h0000]}, 32'h22);
        do_read(16'hFFFF, 2);
        cs_idle(1);

        // Bad instruction, then a normal READ.
        w0 = wr_cnt;
        o0 = out_cnt;
        send(1'b0, 4'h0);
        send(1'b0, 4'h5);
        for (int i = 0; i < 8; i++) send(1'b0, 4'($urandom));
        chk("bad_wr_en", 32'(wr_cnt - w0), 32'd0);
        chk("bad_mode", 32'(out_cnt - o0), 32'd0);
        cs_idle(1);
        do_read(16'h1234, 2);
        cs_idle(1);

        // Abort a WRITE after its first data nibble.
        keep = ref_mem[16'h4000];
        w0 = wr_cnt;
        send_hdr(SQI_INSTR_WRITE, 16'h4000);
        send(1'b0, 4'h9);
        send(1'b1, 4'h6);
        chk("abort_wr_en", 32'(wr_cnt - w0), 32'd0);
        chk("abort_mem", {24'h0, mem_store[16'h4000]}, {24'h0, keep});

        // Async reset in the middle of the address phase.
        send(1'b0, 4'h0);
        send(1'b0, 4'h2);
        send(1'b0, 4'h1);
        send(1'b0, 4'h2);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("mid_rst");
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        bus.cs = 1'b1;
        cs_idle(1);
        txq = '{8'h5E, 8'hA7};
        do_write(16'h2468);
        do_read(16'h2468, 2);
        cs_idle(1);

        // Back-to-back: 4-byte READ, 2 CS-high edges, then WRITE.
        do_read(16'h1234, 4);
        send(1'b1, 4'h0);
        chk("b2b_mode", {31'h0, bus.mode == SQI_MODE_OUT}, 32'd0);
        send(1'b1, 4'h0);
        txq = '{8'h3C, 8'hC3, 8'h0F};
        do_write(16'h1236);

        // Random traffic against the reference model.
        for (int t = 0; t < 30; t++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                txq.delete();
                for (int i = 0; i < int'($urandom_range(1, 4)); i++) txq.push_back(8'($urandom));
                do_write(a);
            end else begin
                do_read(a, int'($urandom_range(1, 4)));
                cs_idle(int'($urandom_range(1, 2)));
            end
        end

        bad = 0;
        for (int i = 0; i < 65536; i++)
            if (mem_store[i] !== ref_mem[i]) bad++;
        chk("mem_full", 32'(bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
